ifetch_unit: RTL and testbench

- Sequential instruction-fetch front end of the RV32I core.
- Owns the program counter and fetches one instruction at a time from the instruction memory port over a request/response handshake.
- Advances the PC by 4 when the decode stage consumes an instruction, and to the redirect target on a taken branch or jump.
- Sits between the instruction memory and decode; replaces the free-running PC register with a fetch unit that tolerates variable memory latency.

---
 rtl/core_pkg.sv | 15 +
 rtl/pc_plus4.sv | 11 +
 rtl/ifetch_unit.sv | 127 ++++++++++++
 tb/tb_ifetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    localparam int unsigned INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pc_plus4.sv
// Unsigned address increment by one instruction word; wraps modulo 2^WIDTH.
module pc_plus4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + WIDTH'(4);

endmodule

// File: rtl/ifetch_unit.sv
// Sequential fetch front end: owns the PC, issues one instruction-memory
// request at a time and presents the fetched word to decode until consumed.
module ifetch_unit
    import core_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [WIDTH-1:0]      imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [WIDTH-1:0]      inst_pc,
    output logic [WIDTH-1:0]      inst_pc_plus4,
    output logic                  fetch_fault
);

    fetch_state_t          state_q, state_d;
    logic [WIDTH-1:0]      pc_q, pc_d;
    logic [WIDTH-1:0]      pc_seq;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0]      inst_pc_q, inst_pc_d;
    logic                  redir_aligned;

    // Sequential successor of the fetch PC.
    pc_plus4 #(.WIDTH(WIDTH)) u_pc_next (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_seq)
    );

    // Link/fall-through address of the instruction presented to decode.
    pc_plus4 #(.WIDTH(WIDTH)) u_inst_pc_plus4 (
        .pc_i       (inst_pc_q),
        .pc_plus4_o (inst_pc_plus4)
    );

    assign redir_aligned = (redirect_pc[1:0] == 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and instruction holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Next-state and next-PC: redirect outranks every handshake event.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (state_q == S_FAULT) begin
            state_d = S_FAULT;
        end else if (redirect_valid) begin
            if (!redir_aligned) begin
                state_d = S_FAULT;
            end else begin
                pc_d = redirect_pc;
                unique case (state_q)
                    // An accepted request still owes us a response to drain.
                    S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
                    S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                    S_HOLD:  state_d = S_REQ;
                    S_DROP:  state_d = S_DROP;
                    default: state_d = S_FAULT;
                endcase
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d   = S_HOLD;
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        state_d = S_REQ;
                        pc_d    = pc_seq;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    // Outputs decoded from registered state; rst only masks the request.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !rst;
        inst_valid     = (state_q == S_HOLD);
        fetch_fault    = (state_q == S_FAULT);
        imem_req_addr  = pc_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with hand-computed expectations.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;
    logic bad_seen = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    // A squashed response must never surface as a valid instruction.
    always @(negedge clk) begin
        if (inst_valid && inst == 32'hDEAD_BEEF) bad_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr", imem_req_addr, 32'h0);

        // First request after reset release
        rst = 1'b0;
        step();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Basic fetch, k = 1
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        step();
        imem_rsp_valid = 1'b0;
        chk("hold_inst_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", inst, 32'h0050_0093);
        chk("hold_inst_pc", inst_pc, 32'h0);
        chk("hold_pc_plus4", inst_pc_plus4, 32'h4);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_inst_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, 32'h0050_0093);
            chk("bp_inst_pc", inst_pc, 32'h0);
            chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        end

        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("next_req_addr", imem_req_addr, 32'h4);
        chk("next_inst_valid", 32'(inst_valid), 32'd0);

        // Squash outstanding fetch
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("drop_addr", imem_req_addr, 32'h100);
        chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (2) step();
        chk("drop_still_waiting", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("after_drop_inst_valid", 32'(inst_valid), 32'd0);
        chk("after_drop_req_valid", 32'(imem_req_valid), 32'd1);
        chk("after_drop_addr", imem_req_addr, 32'h100);

        // Simultaneous consume and redirect
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0113;
        step();
        imem_rsp_valid = 1'b0;
        chk("b2_inst", inst, 32'h00A0_0113);
        chk("b2_inst_pc", inst_pc, 32'h100);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("cr_addr", imem_req_addr, 32'h40);
        chk("cr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("cr_inst_valid", 32'(inst_valid), 32'd0);

        // Wrap-around: redirect in REQ without acceptance
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        step();
        imem_rsp_valid = 1'b0;
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", inst_pc_plus4, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap_next_addr", imem_req_addr, 32'h0);
        chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mis_addr_kept", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_sticky", 32'(fetch_fault), 32'd1);
            chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
            chk("fault_inst_valid", 32'(inst_valid), 32'd0);
        end
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;

        // Reset clears fault; a stray response afterwards is ignored
        rst = 1'b1;
        step();
        chk("rst2_fault", 32'(fetch_fault), 32'd0);
        chk("rst2_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_req_addr, 32'h0);
        step();
        imem_rsp_valid = 1'b0;
        chk("stray_rsp_ignored", 32'(imem_req_valid), 32'd1);
        chk("stray_inst_valid", 32'(inst_valid), 32'd0);

        chk("no_squashed_data", 32'(bad_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
